ifft_output_packer: RTL

Downstream capture stage for the audio processing pipeline. Consumes the real part of the IFFT output stream (one sample per enabled cycle, frame start marked by sync) and converts each sample to signed 16-bit by shift and saturate. Packs 2048 samples into 64 words of 512 bits, readable by word index for the STE instruction. Signals completion to the CPU with a `done` flag.

---
 rtl/audio_pkg.sv | 15 +
 rtl/ifft_output_packer_if.sv | 26 ++
 rtl/sample_saturator.sv | 24 ++
 rtl/ifft_output_packer.sv | 101 ++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: constants and state type shared by the audio capture/buffer blocks
package audio_pkg;
    localparam int SIZE      = 16;
    localparam int SAMPLES   = 2048;
    localparam int WORD_BITS = 512;
    localparam int WORDS     = SAMPLES * SIZE / WORD_BITS;
    localparam int LANES     = WORD_BITS / SIZE;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURING,
        DONE
    } packer_state_t;
endpackage

// File: rtl/ifft_output_packer_if.sv
// ifft_output_packer_if: sample stream, word read port and status of the IFFT output packer
interface ifft_output_packer_if
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 28
);
    logic                          start;
    logic                          sample_valid;
    logic                          sample_sync;
    logic signed [SAMPLE_BITS-1:0] sample_in;
    logic [$clog2(WORDS)-1:0]      output_index;
    logic [WORD_BITS-1:0]          data_out;
    logic                          busy;
    logic                          done;
    logic                          clipped;

    modport master (
        output start, sample_valid, sample_sync, sample_in, output_index,
        input  data_out, busy, done, clipped
    );

    modport slave (
        input  start, sample_valid, sample_sync, sample_in, output_index,
        output data_out, busy, done, clipped
    );
endinterface

// File: rtl/sample_saturator.sv
// sample_saturator: arithmetic right shift then clamp to a signed SIZE-bit sample
module sample_saturator #(
    parameter int SAMPLE_BITS = 28,
    parameter int SIZE        = 16,
    parameter int SHIFT       = 8
) (
    input  logic signed [SAMPLE_BITS-1:0] in,
    output logic signed [SIZE-1:0]        out,
    output logic                          sat
);
    localparam logic signed [SAMPLE_BITS-1:0] MAX_V = SAMPLE_BITS'((1 << (SIZE - 1)) - 1);
    localparam logic signed [SAMPLE_BITS-1:0] MIN_V = ~MAX_V;

    logic signed [SAMPLE_BITS-1:0] w_shifted;
    logic                          w_hi;
    logic                          w_lo;

    assign w_shifted = in >>> SHIFT;
    assign w_hi      = w_shifted > MAX_V;
    assign w_lo      = w_shifted < MIN_V;
    assign sat       = w_hi | w_lo;
    assign out       = w_hi ? {1'b0, {(SIZE - 1){1'b1}}} :
                       w_lo ? {1'b1, {(SIZE - 1){1'b0}}} : w_shifted[SIZE-1:0];
endmodule

// File: rtl/ifft_output_packer.sv
// ifft_output_packer: captures one IFFT frame as saturated 16-bit samples packed into readable 512-bit words
module ifft_output_packer
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 28,
    parameter int SHIFT       = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    ifft_output_packer_if.slave bus
);
    localparam int CNT_W  = $clog2(SAMPLES);
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = $clog2(WORDS);

    packer_state_t          r_state;
    packer_state_t          w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [WORD_BITS-1:0]   r_acc;
    logic [WORD_BITS-1:0]   w_acc_next;
    logic [WORD_BITS-1:0]   r_mem [WORDS];
    logic [WORD_BITS-1:0]   r_data;
    logic                   r_clipped;
    logic signed [SIZE-1:0] w_sample;
    logic                   w_sat;
    logic                   w_arm;
    logic                   w_accept;
    logic                   w_last;
    logic [LANE_W-1:0]      w_lane;
    logic [IDX_W-1:0]       w_word;

    sample_saturator #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .SIZE        (SIZE),
        .SHIFT       (SHIFT)
    ) u_sat (
        .in  (bus.sample_in),
        .out (w_sample),
        .sat (w_sat)
    );

    assign w_arm    = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_accept = bus.sample_valid && ((r_state == ARMED && bus.sample_sync) || r_state == CAPTURING);
    assign w_last   = r_cnt == CNT_W'(SAMPLES - 1);
    assign w_lane   = r_cnt[LANE_W-1:0];
    assign w_word   = r_cnt[CNT_W-1 -: IDX_W];

    assign bus.data_out = r_data;
    assign bus.busy     = r_state == ARMED || r_state == CAPTURING;
    assign bus.done     = r_state == DONE;
    assign bus.clipped  = r_clipped;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: sync is only honoured while armed; the frame ends on its last accepted sample
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (bus.start) w_next = ARMED;
            ARMED:      if (bus.sample_valid && bus.sample_sync) w_next = CAPTURING;
            CAPTURING:  if (bus.sample_valid && w_last) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    // Word being assembled, with the current sample dropped into its lane
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[w_lane*SIZE +: SIZE] = w_sample;
    end

    // Sample counter, lane accumulator, sticky clip flag and registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_clipped <= 1'b0;
            r_data    <= '0;
        end else begin
            r_data <= r_mem[bus.output_index];
            if (w_arm) begin
                r_cnt     <= '0;
                r_acc     <= '0;
                r_clipped <= 1'b0;
            end else if (w_accept) begin
                r_cnt     <= r_cnt + 1'b1;
                r_acc     <= w_acc_next;
                r_clipped <= r_clipped | w_sat;
            end
        end
    end

    // Frame memory: a full word is committed as its last lane arrives; never cleared
    always_ff @(posedge clk) begin
        if (w_accept && w_lane == LANE_W'(LANES - 1)) r_mem[w_word] <= w_acc_next;
    end
endmodule
